// File: rtl/c_err_agg.sv
// Error aggregation: sticky per-bit status, first-error index, saturating event
// counter, masked irq, and a req/ack clear port driven by a small Moore FSM.

module c_err_agg_bit (
  input  logic status_q,
  input  logic err,
  input  logic prev,
  input  logic mask_q,
  input  logic in_clr,
  output logic status_nx,
  output logic new_evt
);
  // A level present in the clear cycle re-sets the bit, so new errors win over the clear.
  assign status_nx = (status_q & ~(in_clr & mask_q)) | err;
  assign new_evt   = err & ~prev;
endmodule

module c_err_agg #(
  parameter int num_errors  = 8,
  parameter int count_width = 8,
  parameter int idx_width   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   active,
  input  logic [num_errors-1:0]  errors_in,
  input  logic [num_errors-1:0]  irq_en,
  input  logic                   clr_req,
  input  logic [num_errors-1:0]  clr_mask,
  input  logic                   clr_cnt,
  output logic                   clr_ack,
  output logic [num_errors-1:0]  status,
  output logic                   first_vld,
  output logic [idx_width-1:0]   first_idx,
  output logic [count_width-1:0] err_count,
  output logic                   irq
);
  typedef enum logic [1:0] {IDLE, PEND, CLR} state_t;

  state_t                 state_q, state_d;
  logic [num_errors-1:0]  status_q, status_d, prev_q, prev_d;
  logic [num_errors-1:0]  clr_mask_q, clr_mask_d, status_nx, new_evt;
  logic                   clr_cnt_q, clr_cnt_d, first_vld_q, first_vld_d;
  logic [idx_width-1:0]   first_idx_q, first_idx_d, lo_idx;
  logic [count_width-1:0] err_count_q, err_count_d;
  logic                   in_clr, full_clr;

  assign in_clr   = (state_q == CLR);
  assign full_clr = in_clr & clr_cnt_q;

  for (genvar g = 0; g < num_errors; g++) begin : g_bit
    c_err_agg_bit u_bit (
      .status_q (status_q[g]),
      .err      (errors_in[g]),
      .prev     (prev_q[g]),
      .mask_q   (clr_mask_q[g]),
      .in_clr   (in_clr),
      .status_nx(status_nx[g]),
      .new_evt  (new_evt[g])
    );
  end

  always_comb begin
    lo_idx = '0;
    for (int i = num_errors - 1; i >= 0; i--)
      if (errors_in[i]) lo_idx = idx_width'(i);
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    prev_d      = prev_q;
    clr_mask_d  = clr_mask_q;
    clr_cnt_d   = clr_cnt_q;
    err_count_d = err_count_q;
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;
    if (active) begin
      status_d    = status_nx;
      prev_d      = errors_in;
      err_count_d = full_clr ? '0 : err_count_q;
      if (|new_evt && err_count_d != '1) err_count_d = err_count_d + count_width'(1);
      first_vld_d = full_clr ? 1'b0 : first_vld_q;
      first_idx_d = full_clr ? '0 : first_idx_q;
      if (!first_vld_d && |errors_in) begin
        first_vld_d = 1'b1;
        first_idx_d = lo_idx;
      end
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_d    = CLR;
            clr_mask_d = clr_mask;
            clr_cnt_d  = clr_cnt;
          end else if (|errors_in) begin
            state_d = PEND;
          end
        end
        PEND: begin
          if (clr_req) begin
            state_d    = CLR;
            clr_mask_d = clr_mask;
            clr_cnt_d  = clr_cnt;
          end
        end
        CLR:     state_d = (|status_nx) ? PEND : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      status_q    <= '0;
      prev_q      <= '0;
      clr_mask_q  <= '0;
      clr_cnt_q   <= 1'b0;
      err_count_q <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      prev_q      <= prev_d;
      clr_mask_q  <= clr_mask_d;
      clr_cnt_q   <= clr_cnt_d;
      err_count_q <= err_count_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign clr_ack   = in_clr;
  assign status    = status_q;
  assign first_vld = first_vld_q;
  assign first_idx = first_idx_q;
  assign err_count = err_count_q;
  assign irq       = |(status_q & irq_en);
endmodule
